booth_controller: RTL

Sequencing controller for the 6-bit radix-2 Booth multiplier datapath. Accepts an operand pair via a start/ready handshake and drives the datapath's load, clear and shift strobes. Generates the adder operand `x_adder` (0, +x or -x) from the Booth pair `output_y[1:0]`, counts iterations, and signals completion. Sits between the system-level requester and the datapath; it is the only driver of the datapath's control inputs.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_operand_sel.sv | 24 ++
 rtl/booth_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
// State encoding, Booth pair codes and the default operand width.
package booth_pkg;

    localparam int BOOTH_N = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] BP_NOP0 = 2'b00;
    localparam logic [1:0] BP_ADD  = 2'b01;
    localparam logic [1:0] BP_SUB  = 2'b10;
    localparam logic [1:0] BP_NOP1 = 2'b11;

endpackage

// File: rtl/booth_operand_sel.sv
// Adder operand selector: 0, +xr or -xr (mod 2^N) from a Booth pair.
// Purely combinational; the caller decides when the select is held.
module booth_operand_sel
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
) (
    input  logic [N-1:0] xr,
    input  logic [1:0]   sel,
    output logic [N-1:0] x_adder
);

    // Decode the Booth pair into the adder operand
    always_comb begin
        x_adder = '0;
        unique case (sel)
            BP_ADD:           x_adder = xr;
            BP_SUB:           x_adder = -xr;
            BP_NOP0, BP_NOP1: x_adder = '0;
            default:          x_adder = '0;
        endcase
    end

endmodule

// File: rtl/booth_controller.sv
// Sequencing controller for the 6-bit radix-2 Booth multiplier datapath.
// Optional BOOTH_CTRL_OVF_FLAG_EN adds the ovf output for the x = -32 wrap.
module booth_controller
    import booth_pkg::*;
#(
    parameter int N     = BOOTH_N,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x_in,
    input  logic [1:0]   y_bits,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         ldx,
    output logic         ldy,
    output logic         rst_p,
    output logic         ldp,
    output logic         shift_p,
    output logic         shift_y,
    output logic [N-1:0] x_adder
`ifdef BOOTH_CTRL_OVF_FLAG_EN
    ,
    output logic         ovf
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state;
    logic [N-1:0]     xr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel_q;
    logic [1:0]       sel;

    // Live pair in ADD, the held pair in SHIFT, otherwise a zero operand
    always_comb begin
        sel = BP_NOP0;
        if (state == ADD) begin
            sel = y_bits;
        end else if (state == SHIFT) begin
            sel = sel_q;
        end
    end

    booth_operand_sel #(
        .N(N)
    ) u_sel (
        .xr      (xr),
        .sel     (sel),
        .x_adder (x_adder)
    );

    // Main FSM; strobes are registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            xr      <= '0;
            cnt     <= '0;
            sel_q   <= BP_NOP0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            ldx     <= 1'b0;
            ldy     <= 1'b0;
            rst_p   <= 1'b0;
            ldp     <= 1'b0;
            shift_p <= 1'b0;
            shift_y <= 1'b0;
        end else begin
            done    <= 1'b0;
            ldx     <= 1'b0;
            ldy     <= 1'b0;
            rst_p   <= 1'b0;
            ldp     <= 1'b0;
            shift_p <= 1'b0;
            shift_y <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= x_in;
                        cnt   <= '0;
                        state <= LOAD;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        ldx   <= 1'b1;
                        ldy   <= 1'b1;
                        rst_p <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= ADD;
                    ldp   <= 1'b1;
                end
                ADD: begin
                    sel_q   <= y_bits;
                    state   <= SHIFT;
                    shift_p <= 1'b1;
                    shift_y <= 1'b1;
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ADD;
                        ldp   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BOOTH_CTRL_OVF_FLAG_EN
    localparam logic [N-1:0] X_MIN = {1'b1, {(N-1){1'b0}}};

    logic sub_seen;

    // Remember any -x use this operation; report it with done for x = min
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_seen <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (state == LOAD) begin
                sub_seen <= 1'b0;
            end else if (state == ADD && y_bits == BP_SUB) begin
                sub_seen <= 1'b1;
            end
            if (state == SHIFT && cnt == LAST && xr == X_MIN) begin
                ovf <= sub_seen;
            end
        end
    end
`endif

endmodule
